gl_matrix_stack_ctrl: RTL
=========================

Name: gl_matrix_stack_ctrl

Overview:
- Services the push/pop requests that the command decoder issues for the modelview and projection matrices.
- Keeps one stack pointer per matrix mode.
- Sequences the 16-word copy between the current-matrix RAM and the stack RAM.
- Flags overflow and underflow, and holds busy so the decoder stalls the command stream until the copy completes.

Parameters:
- MV_DEPTH, 32, number of modelview stack slots.
- PROJ_DEPTH, 2, number of projection stack slots.
- SP_W, 6, stack pointer width; must hold the value MV_DEPTH.
- STK_AW, 10, stack RAM word-address width; must cover (MV_DEPTH+PROJ_DEPTH)*16.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- push_en  input  1  push request, sampled each clock edge.
- pop_en  input  1  pop request, sampled each clock edge.
- matrix_mode  input  1  target stack: 0 = modelview, 1 = projection.
- mat_addr  output  5  current-matrix RAM word address: mode*16 + word.
- mat_rd_data  input  32  current-matrix RAM read data; valid 1 cycle after mat_addr.
- mat_wr_data  output  32  current-matrix RAM write data.
- mat_we  output  1  current-matrix RAM write enable.
- stk_addr  output  STK_AW  stack RAM word address.
- stk_rd_data  input  32  stack RAM read data; valid 1 cycle after stk_addr.
- stk_wr_data  output  32  stack RAM write data.
- stk_we  output  1  stack RAM write enable.
- busy  output  1  copy in progress; decoder holds its stall while high.
- done  output  1  1-cycle pulse when a copy completes.
- overflow  output  1  1-cycle pulse: push rejected because the stack is full.
- underflow  output  1  1-cycle pulse: pop rejected because the stack is empty.
- mv_sp  output  SP_W  modelview stack depth.
- proj_sp  output  SP_W  projection stack depth.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, overflow=0, underflow=0, mat_we=0, stk_we=0, all addresses 0, all write data 0, mv_sp=0, proj_sp=0, state IDLE.
- States: IDLE, PUSH, POP.
- Stack slot base address:
  - modelview: sp*16
  - projection: MV_DEPTH*16 + sp*16
- Requests are accepted only in IDLE. While busy=1, push_en and pop_en are ignored, with no error pulse.
- Push and pop high together in IDLE: push is taken and pop is dropped.
- matrix_mode is latched at accept and used for the whole copy.
- PUSH, when sp(mode) < depth(mode):
  - Edge T: busy<=1, state<=PUSH, word counter=0, mat_addr<=mode*16.
  - Edges T+1..T+15: mat_addr advances by 1 per cycle.
  - Edges T+1..T+16: stk_we=1; stk_addr = slot(sp)+i for i=0..15; stk_wr_data = mat_rd_data.
  - Edge T+17: stk_we<=0, busy<=0, done<=1, sp(mode)<=sp+1, state<=IDLE.
- POP, when sp(mode) > 0:
  - Same timing as PUSH, with the roles of the two RAMs swapped.
  - Reads come from stk_addr = slot(sp-1)+i; writes go to mat_addr = mode*16+i with mat_we=1 and mat_wr_data = stk_rd_data.
  - At edge T+17: sp(mode)<=sp-1.
- Copy latency: busy is high for exactly 17 cycles; 16 writes occur on consecutive cycles with no gaps.
- Push when sp = depth: no RAM access, overflow=1 for one cycle, sp unchanged, busy stays 0.
- Pop when sp = 0: underflow=1 for one cycle, otherwise as the overflow case.
- The pointer updates only at completion, so mv_sp/proj_sp read the old value while busy.
- The other mode's pointer is never touched.
- done, overflow and underflow are never asserted in the same cycle.
- Reset mid-copy: on the reset edge, all write enables drop and both pointers clear. A partially written slot is not restored, and done is not pulsed.
- Pointer arithmetic never wraps; the full/empty checks are the only guards.

Test Plan:
- Reset, then push with mode 0 and current modelview words = 0x3F800000+i → stack words 0..15 hold the same values; busy high 17 cycles; done pulses once; mv_sp=1; proj_sp=0.
- Push mode 0, overwrite current matrix with zeros, pop mode 0 → mat words 0..15 restored to 0x3F800000+i; mv_sp=0.
- Push mode 1 three times → first two succeed (stk_addr base 512 then 528); third gives overflow=1 for one cycle, no writes, proj_sp=2.
- Pop mode 0 with mv_sp=0 → underflow=1 for one cycle, mat_we never asserted, busy stays 0.
- push_en and pop_en high together in IDLE → push executes; push_en pulsed at busy cycle 5 → ignored, mv_sp increments by exactly 1.
- Assert rst at busy cycle 8 of a push → next cycle stk_we=0, busy=0, mv_sp=0, done never pulses.

Source files
------------

// File: rtl/gl_matrix_stack_ctrl.sv
// gl_matrix_stack_ctrl: push/pop sequencer copying 16-word matrices between current-matrix RAM and stack RAM
module gl_matrix_stack_ctrl #(
  parameter int MV_DEPTH   = 32,
  parameter int PROJ_DEPTH = 2,
  parameter int SP_W       = 6,
  parameter int STK_AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_en,
  input  logic              pop_en,
  input  logic              matrix_mode,
  output logic [4:0]        mat_addr,
  input  logic [31:0]       mat_rd_data,
  output logic [31:0]       mat_wr_data,
  output logic              mat_we,
  output logic [STK_AW-1:0] stk_addr,
  input  logic [31:0]       stk_rd_data,
  output logic [31:0]       stk_wr_data,
  output logic              stk_we,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              underflow,
  output logic [SP_W-1:0]   mv_sp,
  output logic [SP_W-1:0]   proj_sp
);
  typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n, mat_addr_n;
  logic mode, mode_n, mat_we_n, stk_we_n, busy_n, done_n, overflow_n, underflow_n;
  logic [STK_AW-1:0] slot_base, slot_base_n, stk_addr_n;
  logic [31:0] mat_wr_data_n, stk_wr_data_n;
  logic [SP_W-1:0] mv_sp_n, proj_sp_n, sp_cur, depth_cur;
  function automatic logic [STK_AW-1:0] slot_of(input logic m, input logic [SP_W-1:0] sp);
    return (m ? STK_AW'(MV_DEPTH * 16) : '0) + (STK_AW'(sp) << 4);
  endfunction
  assign sp_cur    = matrix_mode ? proj_sp : mv_sp;
  assign depth_cur = matrix_mode ? SP_W'(PROJ_DEPTH) : SP_W'(MV_DEPTH);
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    mode_n        = mode;
    slot_base_n   = slot_base;
    mat_addr_n    = mat_addr;
    stk_addr_n    = stk_addr;
    mat_wr_data_n = mat_wr_data;
    stk_wr_data_n = stk_wr_data;
    mv_sp_n       = mv_sp;
    proj_sp_n     = proj_sp;
    busy_n        = busy;
    mat_we_n      = 1'b0;
    stk_we_n      = 1'b0;
    done_n        = 1'b0;
    overflow_n    = 1'b0;
    underflow_n   = 1'b0;
    case (state)
      IDLE: begin
        if (push_en) begin
          if (sp_cur < depth_cur) begin
            state_n     = PUSH;
            busy_n      = 1'b1;
            cnt_n       = '0;
            mode_n      = matrix_mode;
            slot_base_n = slot_of(matrix_mode, sp_cur);
            mat_addr_n  = {matrix_mode, 4'd0};
          end else
            overflow_n = 1'b1;
        end else if (pop_en) begin
          if (sp_cur != '0) begin
            state_n     = POP;
            busy_n      = 1'b1;
            cnt_n       = '0;
            mode_n      = matrix_mode;
            slot_base_n = slot_of(matrix_mode, sp_cur - 1'b1);
            stk_addr_n  = slot_of(matrix_mode, sp_cur - 1'b1);
          end else
            underflow_n = 1'b1;
        end
      end
      default: begin
        if (cnt == 5'd16) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          mv_sp_n   = mode ? mv_sp : (state == PUSH ? mv_sp + 1'b1 : mv_sp - 1'b1);
          proj_sp_n = !mode ? proj_sp : (state == PUSH ? proj_sp + 1'b1 : proj_sp - 1'b1);
        end else begin
          cnt_n = cnt + 5'd1;
          // Read address runs one word ahead of the write, stopping at the last word
          if (state == PUSH) begin
            stk_we_n      = 1'b1;
            stk_addr_n    = slot_base + STK_AW'(cnt);
            stk_wr_data_n = mat_rd_data;
            mat_addr_n    = cnt < 5'd15 ? {mode, cnt[3:0] + 4'd1} : mat_addr;
          end else begin
            mat_we_n      = 1'b1;
            mat_addr_n    = {mode, cnt[3:0]};
            mat_wr_data_n = stk_rd_data;
            stk_addr_n    = cnt < 5'd15 ? slot_base + STK_AW'(cnt + 5'd1) : stk_addr;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mode        <= 1'b0;
      slot_base   <= '0;
      mat_addr    <= '0;
      stk_addr    <= '0;
      mat_wr_data <= '0;
      stk_wr_data <= '0;
      mat_we      <= 1'b0;
      stk_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      mv_sp       <= '0;
      proj_sp     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mode        <= mode_n;
      slot_base   <= slot_base_n;
      mat_addr    <= mat_addr_n;
      stk_addr    <= stk_addr_n;
      mat_wr_data <= mat_wr_data_n;
      stk_wr_data <= stk_wr_data_n;
      mat_we      <= mat_we_n;
      stk_we      <= stk_we_n;
      busy        <= busy_n;
      done        <= done_n;
      overflow    <= overflow_n;
      underflow   <= underflow_n;
      mv_sp       <= mv_sp_n;
      proj_sp     <= proj_sp_n;
    end
  end
endmodule
